// File: rtl/home_inventory_regmap_pkg.sv
// Shared regmap offsets, SNAPSHOT command word and poller FSM encoding
// for the home-inventory ADC poller and its Wishbone initiator port.
package home_inventory_regmap_pkg;

    localparam logic [31:0] ADR_ADC_CMD     = 32'h0000_0204;
    localparam logic [31:0] ADR_ADC_RAW_CH0 = 32'h0000_0210;
    localparam logic [31:0] ADR_TARE_CH0    = 32'h0000_0300;
    localparam logic [31:0] ADR_STRIDE      = 32'd4;
    localparam logic [31:0] ADC_SNAPSHOT    = 32'h0000_0001;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SNAP_REQ,
        ST_SNAP_ACK,
        ST_RD_REQ,
        ST_RD_ACK,
        ST_TR_REQ,
        ST_TR_ACK,
        ST_PUSH,
        ST_GAP
    } poll_state_t;

    function automatic logic [31:0] ch_offset(input logic [2:0] ch);
        return 32'(ch) * ADR_STRIDE;
    endfunction

endpackage

// File: rtl/home_inventory_wbm_port.sv
// Single-transaction Wishbone initiator with ack timeout.
// Ports: req/we/adr/dat/sel in, done/timeout/rdata out, wb_* bus side.
module home_inventory_wbm_port #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tcnt;

    // done/timeout are same-cycle strobes so the sequencer can move on
    // at the very edge the bus drops, keeping one idle cycle between
    // accesses.
    assign done    = wb_stb & wb_ack;
    assign timeout = wb_stb & ~wb_ack & (tcnt == T_LAST);
    assign rdata   = wb_dat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_w <= '0;
            wb_sel   <= '0;
            tcnt     <= '0;
        end else if (!wb_cyc) begin
            if (req) begin
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
                wb_we    <= we;
                wb_adr   <= adr;
                wb_dat_w <= dat;
                wb_sel   <= sel;
                tcnt     <= '0;
            end
        end else if (done || timeout) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_w <= '0;
            wb_sel   <= '0;
            tcnt     <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/home_inventory_wb_adc_poller.sv
// ADC frame poller: SNAPSHOT write, then RAW_CHn reads streamed out as
// samples. Optional HOME_INV_POLL_TARE_EN subtracts TARE_CHn per sample.
module home_inventory_wb_adc_poller
    import home_inventory_regmap_pkg::*;
#(
    parameter logic [31:0] ADR_BASE    = 32'h0000_0000,
    parameter int          NUM_CH_MAX  = 8,
    parameter int          TIMEOUT_CYC = 16,
    parameter int          PERIOD_W    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable_i,
    input  logic [3:0]          num_ch_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                smp_valid_o,
    input  logic                smp_ready_i,
    output logic [2:0]          smp_ch_o,
    output logic [31:0]         smp_data_o,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam logic [3:0] NCH_MAX = 4'(NUM_CH_MAX);

    poll_state_t         state;
    logic [3:0]          nch;
    logic [2:0]          ch;
    logic [PERIOD_W-1:0] gap_cnt;
    logic                en_q;
    logic                req;
    logic                we;
    logic [31:0]         adr;
    logic [31:0]         dat;
    logic [3:0]          sel;
    logic                done;
    logic                timeout;
    logic [31:0]         rdata;
    logic                last;
`ifdef HOME_INV_POLL_TARE_EN
    logic [31:0]         raw;
`endif

    assign smp_ch_o = ch;
    assign last     = ({1'b0, ch} == nch - 4'd1);

    always_comb begin
        req = 1'b0;
        we  = 1'b0;
        adr = '0;
        dat = '0;
        sel = '0;
        case (state)
            ST_SNAP_REQ: begin
                req = 1'b1;
                we  = 1'b1;
                adr = ADR_BASE + ADR_ADC_CMD;
                dat = ADC_SNAPSHOT;
                sel = 4'b0001;
            end
            ST_RD_REQ: begin
                req = 1'b1;
                adr = ADR_BASE + ADR_ADC_RAW_CH0 + ch_offset(ch);
                sel = 4'hF;
            end
`ifdef HOME_INV_POLL_TARE_EN
            ST_TR_REQ: begin
                req = 1'b1;
                adr = ADR_BASE + ADR_TARE_CH0 + ch_offset(ch);
                sel = 4'hF;
            end
`endif
            default: ;
        endcase
    end

    home_inventory_wbm_port #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_port (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .req      (req),
        .we       (we),
        .adr      (adr),
        .dat      (dat),
        .sel      (sel),
        .done     (done),
        .timeout  (timeout),
        .rdata    (rdata),
        .wb_cyc   (wbm_cyc_o),
        .wb_stb   (wbm_stb_o),
        .wb_we    (wbm_we_o),
        .wb_adr   (wbm_adr_o),
        .wb_dat_w (wbm_dat_o),
        .wb_sel   (wbm_sel_o),
        .wb_dat_r (wbm_dat_i),
        .wb_ack   (wbm_ack_i)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= ST_IDLE;
            nch          <= '0;
            ch           <= '0;
            gap_cnt      <= '0;
            en_q         <= 1'b0;
            smp_valid_o  <= 1'b0;
            smp_data_o   <= '0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
`ifdef HOME_INV_POLL_TARE_EN
            raw          <= '0;
`endif
        end else begin
            en_q         <= enable_i;
            frame_done_o <= 1'b0;
            if (en_q && !enable_i)
                err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i && num_ch_i != 4'd0) begin
                        nch    <= (num_ch_i > NCH_MAX) ? NCH_MAX : num_ch_i;
                        ch     <= '0;
                        busy_o <= 1'b1;
                        state  <= ST_SNAP_REQ;
                    end
                end
                ST_SNAP_REQ: state <= ST_SNAP_ACK;
                ST_RD_REQ:   state <= ST_RD_ACK;
`ifdef HOME_INV_POLL_TARE_EN
                ST_TR_REQ:   state <= ST_TR_ACK;
`endif
                ST_SNAP_ACK, ST_RD_ACK, ST_TR_ACK: begin
                    if (done) begin
                        case (state)
                            ST_SNAP_ACK: state <= ST_RD_REQ;
`ifdef HOME_INV_POLL_TARE_EN
                            ST_RD_ACK: begin
                                raw   <= rdata;
                                state <= ST_TR_REQ;
                            end
                            ST_TR_ACK: begin
                                smp_data_o  <= raw - rdata;
                                smp_valid_o <= 1'b1;
                                state       <= ST_PUSH;
                            end
`else
                            ST_RD_ACK: begin
                                smp_data_o  <= rdata;
                                smp_valid_o <= 1'b1;
                                state       <= ST_PUSH;
                            end
`endif
                            default: state <= ST_IDLE;
                        endcase
                    end else if (timeout) begin
                        // abandon frame silently; err_o flags it
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        gap_cnt <= period_i;
                        state   <= ST_GAP;
                    end
                end
                ST_PUSH: begin
                    if (smp_ready_i) begin
                        smp_valid_o <= 1'b0;
                        if (last) begin
                            frame_done_o <= 1'b1;
                            busy_o       <= 1'b0;
                            gap_cnt      <= period_i;
                            state        <= ST_GAP;
                        end else begin
                            ch    <= ch + 3'd1;
                            state <= ST_RD_REQ;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - PERIOD_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_home_inventory_wb_adc_poller.sv
// Scoreboard bench for home_inventory_wb_adc_poller with a regmap
// responder (SNAPSHOT stub, RAW_CHn, TARE_CHn).
module tb_home_inventory_wb_adc_poller;

    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_t;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] data;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  num_ch = 4'd4;
    logic [15:0] period = 16'd0;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        valid, ready;
    logic [2:0]  ch;
    logic [31:0] data;
    logic        fdone, busy, err;

    int checks = 0;
    int errs = 0;
    bus_t bus_q[$];
    smp_t smp_q[$];
    logic bus_chk = 1'b0;
    logic len_chk = 1'b1;
    int   last_len = 0;
    int   run = 0;
    logic stall = 1'b0;
    logic [31:0] snapc = 0;
    logic [31:0] tare [8];

    always #5 clk = ~clk;

    home_inventory_wb_adc_poller #(
        .ADR_BASE(BASE), .NUM_CH_MAX(8), .TIMEOUT_CYC(16), .PERIOD_W(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(enable),
        .num_ch_i(num_ch), .period_i(period),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_w),
        .wbm_dat_i(dat_r), .wbm_ack_i(ack),
        .smp_valid_o(valid), .smp_ready_i(ready), .smp_ch_o(ch),
        .smp_data_o(data), .frame_done_o(fdone), .busy_o(busy),
        .err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_smp(input int f, input int i);
        logic [31:0] v;
        v = 32'h1000 + 32'(f) + 32'(i);
`ifdef HOME_INV_POLL_TARE_EN
        v = v - tare[i];
`endif
        return v;
    endfunction

    task automatic push_frame(input int f, input int n, input bit bus);
        bus_t b;
        smp_t s;
        if (bus) begin
            b = '{1'b1, BASE + 32'h204, 32'h1, 4'h1};
            bus_q.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            s = '{3'(i), exp_smp(f, i)};
            smp_q.push_back(s);
            if (bus) begin
                b = '{1'b0, BASE + 32'h210 + 32'(4 * i), 32'h0, 4'hF};
                bus_q.push_back(b);
`ifdef HOME_INV_POLL_TARE_EN
                b = '{1'b0, BASE + 32'h300 + 32'(4 * i), 32'h0, 4'hF};
                bus_q.push_back(b);
`endif
            end
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < 3000 && seen < n; i++) begin
            @(negedge clk);
            if (fdone) seen++;
        end
        chk(tag, 32'(seen), 32'(n));
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd1);
    endtask

    // responder: ack one cycle after accept
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            dat_r <= '0;
        end else if (cyc && stb && !ack &&
                     !(stall && adr == BASE + 32'h214)) begin
            ack   <= 1'b1;
            dat_r <= '0;
            if (we) begin
                if (adr == BASE + 32'h204 && dat_w[0])
                    snapc <= snapc + 1;
            end else if (adr >= BASE + 32'h210 && adr < BASE + 32'h230) begin
                dat_r <= 32'h1000 + snapc + ((adr - BASE - 32'h210) >> 2);
            end else if (adr >= BASE + 32'h300 && adr < BASE + 32'h320) begin
                dat_r <= tare[(adr - BASE - 32'h300) >> 2];
            end
        end else begin
            ack <= 1'b0;
        end
    end

    // monitors sample just before the rising edge
    always begin
        @(negedge clk);
        #4;
        if (rst_n && valid && ready) begin
            if (smp_q.size() == 0) begin
                chk("smp_unexp", 32'(smp_q.size()), 32'd1);
            end else begin
                smp_t e;
                e = smp_q.pop_front();
                chk("smp_ch", {29'd0, ch}, {29'd0, e.ch});
                chk("smp_data", data, e.data);
            end
        end
        if (rst_n && bus_chk && cyc && stb && ack) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexp", 32'(bus_q.size()), 32'd1);
            end else begin
                bus_t b;
                b = bus_q.pop_front();
                chk("bus_we", {31'd0, we}, {31'd0, b.we});
                chk("bus_adr", adr, b.adr);
                chk("bus_dat", dat_w, b.dat);
                chk("bus_sel", {28'd0, sel}, {28'd0, b.sel});
            end
        end
        if (stb) begin
            run++;
        end else if (run != 0) begin
            last_len = run;
            if (len_chk) chk("stb_len", 32'(run), 32'd2);
            run = 0;
        end
    end

    initial begin
        int n;
        int idle;
        int fd;
        ready = 1'b1;
        foreach (tare[i]) tare[i] = 32'h0;
`ifdef HOME_INV_POLL_TARE_EN
        tare[0] = 32'h1002;
        tare[3] = 32'h0000_0010;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_stb", {31'd0, stb}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_sel", {28'd0, sel}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cyc", {31'd0, cyc}, 0);

        // frames 1 and 2 back to back, enable dropped mid-frame 2
        push_frame(1, 4, 1);
        push_frame(2, 4, 1);
        bus_chk = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!cyc && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (cyc && n < 20) begin @(negedge clk); n++; end
        while (!cyc && n < 20) begin @(negedge clk); n++; end
        chk("acc_period", 32'(n), 32'd3);
        wait_frames(1, "f1_done");
        wait_busy("f2_start");
        enable = 1'b0;
        wait_frames(1, "f2_done");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc || busy) n++;
        end
        chk("parked", 32'(n), 0);

        // frames 3 and 4 with a 10-cycle gap
        push_frame(3, 4, 1);
        push_frame(4, 4, 1);
        period = 16'd10;
        enable = 1'b1;
        wait_frames(1, "f3_done");
        idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc) break;
            idle++;
        end
        chk("gap_idle", {31'd0, idle >= 10}, 32'd1);
        enable = 1'b0;
        wait_frames(1, "f4_done");

        // frame 5 backpressure on ch2
        period = 16'd0;
        push_frame(5, 4, 1);
        enable = 1'b1;
        n = 0;
        while (!(busy && ch == 3'd2 && !valid) && n < 200) begin
            @(negedge clk); n++;
        end
        ready = 1'b0;
        enable = 1'b0;
        n = 0;
        while (!valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 20; i++) begin
            chk("bp_data", data, exp_smp(5, 2));
            chk("bp_bus", {31'd0, cyc}, 0);
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", {31'd0, valid}, 0);
        wait_frames(1, "f5_done");

        // frame 6: RAW_CH1 read never acked
        bus_chk = 1'b0;
        len_chk = 1'b0;
        period = 16'd50;
        stall = 1'b1;
        push_frame(6, 1, 0);
        enable = 1'b1;
        fd = 0;
        n = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            if (fdone) fd++;
            n++;
        end
        chk("to_err", {31'd0, err}, 1);
        chk("to_nodone", 32'(fd), 0);
        @(negedge clk);
        chk("to_len", 32'(last_len), 32'd16);
        chk("to_cyc", {31'd0, cyc}, 0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("err_clr", {31'd0, err}, 0);
        stall = 1'b0;

        // frame 7 reset during a RAW read, restart as frame 8
        period = 16'd0;
        num_ch = 4'd2;
        enable = 1'b1;
        n = 0;
        while (!(cyc && !we) && n < 300) begin @(negedge clk); n++; end
        chk("rd_seen", {31'd0, cyc}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'd0, cyc}, 0);
        chk("arst_stb", {31'd0, stb}, 0);
        chk("arst_valid", {31'd0, valid}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        push_frame(8, 2, 1);
        bus_chk = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        len_chk = 1'b1;
        wait_busy("f8_start");
        enable = 1'b0;
        wait_frames(1, "f8_done");

        // frame 9: num_ch clamps to 8
        num_ch = 4'd12;
        push_frame(9, 8, 1);
        enable = 1'b1;
        wait_busy("f9_start");
        enable = 1'b0;
        wait_frames(1, "f9_done");
        repeat (5) @(negedge clk);
        chk("smp_left", 32'(smp_q.size()), 0);
        chk("bus_left", 32'(bus_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
